ysyx_23060240_ifu_fetch: RTL and testbench
==========================================

// Module: ysyx_23060240_ifu_fetch
// PURPOSE
//  Instruction fetch stage, directly upstream of the decoder. Owns the PC and issues one 32-bit fetch per
//  instruction over a valid/ready instruction-memory port. Presents {inst, pc, fault} to decode over a
//  valid/ready handshake. Accepts redirects (jal/jalr/taken branch targets) from execute and squashes
//  wrong-path fetches. Non-pipelined: at most one fetch in flight.
// PARAMETERS
//  RESET_PC  32'h8000_0000  PC value loaded on reset
//  NOP_INST  32'h0000_0013  instruction word (addi x0,x0,0) driven on out_inst when no valid data
// PORTS
//  clk             in   1   single clock, all state on posedge
//  rst             in   1   asynchronous, active-high reset
//  imem_req_valid  out  1   fetch request valid
//  imem_req_ready  in   1   memory accepts request
//  imem_req_addr   out  32  fetch address (= pc, [1:0] always 0)
//  imem_rsp_valid  in   1   fetch data valid
//  imem_rsp_ready  out  1   fetch stage accepts data
//  imem_rsp_data   in   32  fetched instruction word
//  imem_rsp_err    in   1   access fault on this fetch
//  redirect_valid  in   1   one-cycle pulse: change control flow
//  redirect_pc     in   32  new PC; bits [1:0] ignored (forced to 0)
//  out_valid       out  1   instruction available to decode
//  out_ready       in   1   decode consumes instruction
//  out_inst        out  32  instruction word
//  out_pc          out  32  PC of out_inst
//  out_fault       out  1   fetch fault for out_inst (out_inst = NOP_INST)
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE, pc=RESET_PC, redir_pend=0, out_valid=0, out_inst=NOP_INST,
//   out_pc=RESET_PC, out_fault=0; imem_req_valid=0, imem_rsp_ready=0 while in IDLE.
//  FSM (state register; out_* are registered, imem_* decoded from state):
//   IDLE -> REQ unconditionally (first request one cycle after reset release).
//   REQ  : imem_req_valid=1, addr=pc. addr must stay stable until imem_req_ready; on ready -> WAIT.
//   WAIT : imem_rsp_ready=1. On imem_rsp_valid:
//          - squash if redir_pend | redirect_valid: data dropped, pc<=target, redir_pend<=0, -> REQ;
//          - else out_inst<=err?NOP_INST:data, out_fault<=err, out_pc<=pc, out_valid<=1, pc<=pc+4, -> HOLD.
//   HOLD : out_valid=1, all out_* stable until out_valid&out_ready; then out_valid<=0, -> REQ.
//  Redirect rules (redirect always has priority over every other event in the same cycle):
//   - IDLE or REQ without handshake: pc<=redirect_pc now (address change allowed only while not yet
//     accepted in this cycle's req handshake; REQ re-issues with new pc next cycle).
//   - REQ with imem_req_ready in same cycle: request goes out; redir_pend<=1, pend_pc<=redirect_pc, -> WAIT.
//   - WAIT without rsp_valid: redir_pend<=1, pend_pc<=redirect_pc (later redirect overwrites earlier).
//   - HOLD: out_valid<=0, pc<=redirect_pc, -> REQ; a same-cycle out_ready handshake is a squashed transfer
//     (decode receives the same redirect and drops it).
//  pc arithmetic: 32-bit, pc+4 wraps 32'hFFFF_FFFC -> 32'h0000_0000 silently.
//  Latency: no backpressure, 1-cycle memory -> one instruction every 3 cycles (REQ, WAIT, HOLD).
//  Fault: imem_rsp_err does not stall the FSM; fetch continues at pc+4 until redirected.
//  Reset mid-operation: in-flight request abandoned; memory shares rst, so no stale response is accepted.
// STRUCTURE
//  Shared header ysyx_23060240_defines.vh: RESET_PC, NOP_INST, FSM state encodings
//   (IDLE=2'd0, REQ=2'd1, WAIT=2'd2, HOLD=2'd3).
//  Sub-module ysyx_23060240_pc_reg: PC register + next-pc mux (hold / pc+4 / redirect_pc / pend_pc),
//   async-reset to RESET_PC. FSM, pending-redirect register and output regs stay in this module.
// TESTING
//  1 Reset release, mem always ready, 1-cycle rsp, out_ready=1 -> req addrs 8000_0000, 8000_0004, 8000_0008;
//    out_valid every 3rd cycle, out_pc matches, out_inst = rsp data.
//  2 out_ready=0 for 5 cycles in HOLD -> out_* stable, imem_req_valid=0; release -> next addr pc+4.
//  3 redirect_valid pulse to 8000_0100 during WAIT, rsp arrives 2 cycles later with 0x00100093 ->
//    no out_valid; next req addr 8000_0100.
//  4 redirect in HOLD same cycle as out_ready -> out_valid drops, next req addr = redirect_pc;
//    redirect_pc=8000_0203 -> addr 8000_0200.
//  5 imem_rsp_err=1 at 8000_0010 -> out_fault=1, out_inst=0000_0013, next fetch 8000_0014.
//  6 rst asserted in WAIT -> all outputs immediately at reset values; first req after release to RESET_PC;
//    pc=FFFF_FFFC fetch -> next addr 0000_0000.

Source files
------------

// File: rtl/ysyx_23060240_ifu_fetch_pkg.sv
// Shared constants and types for the instruction fetch stage:
// reset PC, NOP encoding, FSM state encoding and next-PC select codes.
package ysyx_23060240_ifu_fetch_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } fetch_state_e;

    typedef enum logic [1:0] {
        PC_HOLD  = 2'd0,
        PC_INC   = 2'd1,
        PC_REDIR = 2'd2,
        PC_PEND  = 2'd3
    } pc_sel_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ysyx_23060240_pc_reg.sv
// Program counter register with its next-PC mux (hold / +4 / redirect / pending redirect).
module ysyx_23060240_pc_reg
    import ysyx_23060240_ifu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  pc_sel_e     sel_i,
    input  logic [31:0] redirect_pc_i,
    input  logic [31:0] pend_pc_i,
    output logic [31:0] pc_o
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    // Both redirect sources are forced word-aligned; +4 wraps naturally at 32 bits.
    always_comb begin
        pc_d = pc_q;
        case (sel_i)
            PC_HOLD:  pc_d = pc_q;
            PC_INC:   pc_d = pc_q + 32'd4;
            PC_REDIR: pc_d = word_align(redirect_pc_i);
            PC_PEND:  pc_d = word_align(pend_pc_i);
            default:  pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/ysyx_23060240_ifu_fetch.sv
// Non-pipelined instruction fetch: one imem request in flight, registered output to decode,
// redirects from execute squash wrong-path fetches.
module ysyx_23060240_ifu_fetch
    import ysyx_23060240_ifu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
    input  logic         clk,
    input  logic         rst,
    output logic         imem_req_valid,
    input  logic         imem_req_ready,
    output logic [31:0]  imem_req_addr,
    input  logic         imem_rsp_valid,
    output logic         imem_rsp_ready,
    input  logic [31:0]  imem_rsp_data,
    input  logic         imem_rsp_err,
    input  logic         redirect_valid,
    input  logic [31:0]  redirect_pc,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_inst,
    output logic [31:0]  out_pc,
    output logic         out_fault,
    output fetch_state_e dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid and its payload stay stable until that edge.
    fetch_state_e state_q;
    logic         redir_pend_q;
    logic [31:0]  pend_pc_q;
    logic         out_valid_q;
    logic [31:0]  out_inst_q;
    logic [31:0]  out_pc_q;
    logic         out_fault_q;
    logic [31:0]  pc;
    pc_sel_e      pc_sel;

    ysyx_23060240_pc_reg #(
        .RESET_PC(RESET_PC)
    ) u_pc_reg (
        .clk          (clk),
        .rst          (rst),
        .sel_i        (pc_sel),
        .redirect_pc_i(redirect_pc),
        .pend_pc_i    (pend_pc_q),
        .pc_o         (pc)
    );

    // The pc may only move while no request is being accepted this cycle.
    always_comb begin
        pc_sel = PC_HOLD;
        case (state_q)
            S_IDLE: if (redirect_valid) pc_sel = PC_REDIR;
            S_REQ:  if (redirect_valid && !imem_req_ready) pc_sel = PC_REDIR;
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    if (redirect_valid)    pc_sel = PC_REDIR;
                    else if (redir_pend_q) pc_sel = PC_PEND;
                    else                   pc_sel = PC_INC;
                end
            end
            S_HOLD: if (redirect_valid) pc_sel = PC_REDIR;
            default: pc_sel = PC_HOLD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            redir_pend_q <= 1'b0;
            pend_pc_q    <= RESET_PC;
            out_valid_q  <= 1'b0;
            out_inst_q   <= NOP_INST;
            out_pc_q     <= RESET_PC;
            out_fault_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: state_q <= S_REQ;
                S_REQ: begin
                    if (imem_req_ready) begin
                        state_q <= S_WAIT;
                        if (redirect_valid) begin
                            redir_pend_q <= 1'b1;
                            pend_pc_q    <= word_align(redirect_pc);
                        end
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (redirect_valid || redir_pend_q) begin
                            redir_pend_q <= 1'b0;
                            state_q      <= S_REQ;
                        end else begin
                            out_inst_q  <= imem_rsp_err ? NOP_INST : imem_rsp_data;
                            out_fault_q <= imem_rsp_err;
                            out_pc_q    <= pc;
                            out_valid_q <= 1'b1;
                            state_q     <= S_HOLD;
                        end
                    end else if (redirect_valid) begin
                        // A later redirect simply overwrites an earlier pending one.
                        redir_pend_q <= 1'b1;
                        pend_pc_q    <= word_align(redirect_pc);
                    end
                end
                S_HOLD: begin
                    if (redirect_valid || out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_REQ;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign imem_req_valid = (state_q == S_REQ);
    assign imem_rsp_ready = (state_q == S_WAIT);
    assign imem_req_addr  = pc;
    assign out_valid      = out_valid_q;
    assign out_inst       = out_inst_q;
    assign out_pc         = out_pc_q;
    assign out_fault      = out_fault_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_ysyx_23060240_ifu_fetch.sv
// Bench for the fetch stage: directed scenarios plus randomized transactions checked
// against a transaction-level model of the expected fetch address and delivered instruction.
module tb_ysyx_23060240_ifu_fetch;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic        imem_rsp_ready;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_fault;
    logic [1:0]  dbg_state;

    int checks   = 0;
    int failures = 0;
    logic [31:0] model_pc;
    logic [31:0] exp_q[$];

    ysyx_23060240_ifu_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_ready(imem_rsp_ready),
        .imem_rsp_data (imem_rsp_data),
        .imem_rsp_err  (imem_rsp_err),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_inst      (out_inst),
        .out_pc        (out_pc),
        .out_fault     (out_fault),
        .dbg_state     (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        imem_rsp_data = $urandom;
    endtask

    task automatic wait_req();
        int n = 0;
        while (imem_req_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("req_seen", imem_req_valid, 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_valid"}, imem_req_valid, 0);
        chk({tag, "_rsp_ready"}, imem_rsp_ready, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_inst"}, out_inst, NOP);
        chk({tag, "_out_pc"}, out_pc, RST_PC);
        chk({tag, "_out_fault"}, out_fault, 0);
        chk({tag, "_state"}, dbg_state, 0);
    endtask

    // kind: 0 none, 1 redirect in REQ before accept, 2 redirect at REQ accept,
    // 3 redirect while waiting for data, 4 redirect with the data, 5 redirect in HOLD with out_ready
    task automatic run_xact(input logic [31:0] data, input logic err, input int req_stall,
                            input int rsp_lat, input int hold, input int kind,
                            input logic [31:0] rpc);
        int          lat;
        logic        squash;
        logic [31:0] target;
        logic [31:0] e_pc;
        lat    = (kind == 3 && rsp_lat == 0) ? 1 : rsp_lat;
        squash = (kind == 2 || kind == 3 || kind == 4);
        target = rpc & 32'hFFFF_FFFC;

        wait_req();
        chk("req_addr", imem_req_addr, model_pc);
        if (kind == 1) begin
            redirect_valid = 1'b1;
            redirect_pc    = rpc;
            tick();
            redirect_valid = 1'b0;
            model_pc       = target;
            chk("redir_req_valid", imem_req_valid, 1);
            chk("redir_req_addr", imem_req_addr, model_pc);
        end
        for (int i = 0; i < req_stall; i++) begin
            tick();
            chk("stall_req_valid", imem_req_valid, 1);
            chk("stall_req_addr", imem_req_addr, model_pc);
        end

        imem_req_ready = 1'b1;
        if (kind == 2) begin
            redirect_valid = 1'b1;
            redirect_pc    = rpc;
        end
        tick();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b0;
        chk("wait_rsp_ready", imem_rsp_ready, 1);
        chk("wait_req_valid", imem_req_valid, 0);

        for (int i = 0; i < lat; i++) begin
            if (kind == 3 && i == 0) begin
                redirect_valid = 1'b1;
                redirect_pc    = rpc;
            end
            if (kind == 3 && i == 1 && lat >= 3) begin
                redirect_valid = 1'b1;
                redirect_pc    = rpc ^ 32'h0000_1000;
                target         = (rpc ^ 32'h0000_1000) & 32'hFFFF_FFFC;
            end
            tick();
            redirect_valid = 1'b0;
            chk("wait_out_valid", out_valid, 0);
            chk("wait_rsp_ready2", imem_rsp_ready, 1);
        end

        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        imem_rsp_err   = err;
        if (kind == 4) begin
            redirect_valid = 1'b1;
            redirect_pc    = rpc;
        end
        @(posedge clk);
        #1;
        imem_rsp_valid = 1'b0;
        imem_rsp_err   = 1'b0;
        imem_rsp_data  = $urandom;
        redirect_valid = 1'b0;

        if (squash) begin
            model_pc = target;
            chk("squash_out_valid", out_valid, 0);
            chk("squash_req_valid", imem_req_valid, 1);
            chk("squash_req_addr", imem_req_addr, model_pc);
            return;
        end

        exp_q.push_back(err ? NOP : data);
        e_pc     = model_pc;
        model_pc = model_pc + 32'd4;
        chk("out_valid", out_valid, 1);
        chk("out_inst", out_inst, exp_q[0]);
        chk("out_pc", out_pc, e_pc);
        chk("out_fault", out_fault, err);

        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_out_valid", out_valid, 1);
            chk("hold_out_inst", out_inst, exp_q[0]);
            chk("hold_out_pc", out_pc, e_pc);
            chk("hold_req_valid", imem_req_valid, 0);
        end

        out_ready = 1'b1;
        if (kind == 5) begin
            redirect_valid = 1'b1;
            redirect_pc    = rpc;
            model_pc       = target;
        end
        tick();
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        void'(exp_q.pop_front());
        chk("rel_out_valid", out_valid, 0);
        chk("rel_req_valid", imem_req_valid, 1);
        chk("rel_req_addr", imem_req_addr, model_pc);
    endtask

    initial begin
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        imem_rsp_err   = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b0;
        model_pc       = RST_PC;

        // Reset and first request one cycle after release.
        tick();
        tick();
        chk_reset_outputs("reset");
        rst = 1'b0;
        chk("idle_req_valid", imem_req_valid, 0);
        tick();
        chk("first_req_valid", imem_req_valid, 1);
        chk("first_req_addr", imem_req_addr, RST_PC);

        // Back-to-back fetches with an ideal memory and decode.
        run_xact(32'h0000_0093, 1'b0, 0, 0, 0, 0, 32'h0);
        run_xact(32'h0010_0113, 1'b0, 0, 0, 0, 0, 32'h0);
        run_xact(32'h0020_0193, 1'b0, 0, 0, 0, 0, 32'h0);

        // Decode backpressure in HOLD.
        run_xact(32'h1234_5678, 1'b0, 0, 0, 5, 0, 32'h0);

        // Redirect during WAIT; the response two cycles later is dropped.
        run_xact(32'h0010_0093, 1'b0, 0, 2, 0, 3, 32'h8000_0100);

        // Redirect in HOLD together with out_ready, unaligned target.
        run_xact(32'hCAFE_0001, 1'b0, 0, 0, 0, 5, 32'h8000_0203);

        // Access fault at 8000_0010, then fetch continues at +4.
        run_xact(32'hDEAD_BEEF, 1'b1, 1, 0, 0, 1, 32'h8000_0010);
        run_xact(32'h0000_0513, 1'b0, 0, 1, 0, 0, 32'h0);

        // Redirect coinciding with request accept, and with response arrival.
        run_xact(32'hAAAA_5555, 1'b0, 2, 1, 0, 2, 32'h8000_0301);
        run_xact(32'h5555_AAAA, 1'b0, 0, 0, 0, 4, 32'h8000_0402);
        run_xact(32'h0FF0_0FF0, 1'b0, 0, 3, 1, 3, 32'h8000_0500);

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            int k;
            k = ($urandom_range(0, 9) < 5) ? 0 : int'($urandom_range(1, 5));
            run_xact($urandom, ($urandom_range(0, 7) == 0), $urandom_range(0, 2),
                     $urandom_range(0, 3), $urandom_range(0, 2), k, $urandom);
        end

        // Reset while a request is in flight.
        wait_req();
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        chk("pre_rst_rsp_ready", imem_rsp_ready, 1);
        rst = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        tick();
        rst      = 1'b0;
        model_pc = RST_PC;
        tick();
        chk("post_rst_req_valid", imem_req_valid, 1);
        chk("post_rst_req_addr", imem_req_addr, RST_PC);

        // PC wrap at the top of the address space.
        run_xact(32'h0000_0001, 1'b0, 0, 0, 0, 1, 32'hFFFF_FFFF);
        run_xact(32'h0000_0002, 1'b0, 0, 0, 0, 0, 32'h0);

        // Redirect during the IDLE cycle after reset release.
        rst = 1'b1;
        tick();
        rst            = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0A02;
        tick();
        redirect_valid = 1'b0;
        model_pc       = 32'h8000_0A00;
        chk("idle_redir_req_valid", imem_req_valid, 1);
        chk("idle_redir_req_addr", imem_req_addr, 32'h8000_0A00);
        run_xact(32'h0000_0003, 1'b0, 0, 0, 0, 0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
